// File: rtl/block_output_pkg.sv
// Shared NoC router definitions: direction codes, flit width, and the
// round-robin scan helper used by the output-stage arbiter.
package block_output_pkg;

  localparam int DIR_LOCAL   = 0;
  localparam int DIR_N       = 1;
  localparam int DIR_E       = 2;
  localparam int DIR_S       = 3;
  localparam int DIR_W       = 4;
  localparam int NUM_PORTS   = 5;
  localparam int FLIT_W      = 8;
  localparam int PKT_LEN_DEF = 4;
  localparam int COORD_W     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping mod NUM_PORTS. The scan runs from the
  // far end so the closest offset to ptr is the one that sticks.
  function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                    input logic [2:0]           ptr);
    pick_t       p;
    int unsigned k;
    p = '0;
    for (int o = NUM_PORTS - 1; o >= 0; o--) begin
      k = (int'(ptr) + o) % NUM_PORTS;
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = 3'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Small circular flit FIFO shared by the router input and output stages.
// Head entry reads as zero while empty; full/empty come from the registered count.
module noc_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_q];

  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/block_output.sv
// Router output stage: per-packet round-robin arbitration over the five input
// blocks targeting OUT_DIR, wormhole-locked grant, output FIFO toward the neighbour.
module block_output
  import block_output_pkg::*;
#(
  parameter logic [2:0] OUT_DIR = 3'd0,
  parameter int         PKT_LEN = 4,
  parameter int         DEPTH   = 4,
  parameter int         DW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    val_in,
  input  logic [3*NUM_PORTS-1:0]  dir_in,
  input  logic [NUM_PORTS*DW-1:0] data_in,
  output logic [NUM_PORTS-1:0]    ret_out,
  output logic                    val_out,
  output logic [DW-1:0]           data_out,
  input  logic                    ret_in,
  output logic                    busy
);

  localparam int CW = $clog2(PKT_LEN + 1);

  logic [NUM_PORTS-1:0] req;
  logic [DW-1:0]        din [NUM_PORTS];
  state_e               state_q;
  logic [2:0]           grant_q, rr_q;
  logic [CW-1:0]        flit_cnt_q;
  pick_t                pick;
  logic                 full, empty, push, pop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign req[i] = val_in[i] & (dir_in[3*i +: 3] == OUT_DIR);
    assign din[i] = data_in[DW*i +: DW];
  end

  assign pick = rr_pick(req, rr_q);
  assign busy = (state_q == ST_BUSY);
  assign push = busy & val_in[grant_q] & ~full;
  assign pop  = ~empty & ret_in;

  always_comb begin
    ret_out = '0;
    if (busy) ret_out[grant_q] = ~full;
  end

  // Grant is only re-evaluated in IDLE, so a stalled or re-routed granted
  // input keeps ownership until its whole packet has been pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      flit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick.found) begin
            grant_q    <= pick.idx;
            flit_cnt_q <= '0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (push) begin
            flit_cnt_q <= flit_cnt_q + 1'b1;
            if (flit_cnt_q == CW'(PKT_LEN - 1)) begin
              state_q <= ST_IDLE;
              rr_q    <= (grant_q == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  noc_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din[grant_q]),
    .dout  (data_out),
    .full  (full),
    .empty (empty)
  );

  assign val_out = ~empty;

endmodule

// File: tb/tb_block_output.sv
// Directed bench for block_output (OUT_DIR=2, PKT_LEN=4, DEPTH=4): upstream sources
// advance on accept, a monitor logs every flit taken by the neighbour.
module tb_block_output;

  logic        clk, rst, val_out, ret_in, busy;
  logic [4:0]  val_in, ret_out;
  logic [14:0] dir_in;
  logic [39:0] data_in;
  logic [7:0]  data_out;

  logic [2:0]  dirs [5];
  logic [7:0]  pat  [5][8];
  int          idx  [5];
  logic [7:0]  got  [$];
  int          total = 0;
  int          bad   = 0;

  block_output #(.OUT_DIR(3'd2), .PKT_LEN(4), .DEPTH(4), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .val_in   (val_in),
    .dir_in   (dir_in),
    .data_in  (data_in),
    .ret_out  (ret_out),
    .val_out  (val_out),
    .data_out (data_out),
    .ret_in   (ret_in),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dir_in  = '0;
    data_in = '0;
    for (int i = 0; i < 5; i++) begin
      dir_in[3*i +: 3]  = dirs[i];
      data_in[8*i +: 8] = pat[i][idx[i] % 8];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst)                        idx[i] <= 0;
      else if (val_in[i] && ret_out[i]) idx[i] <= idx[i] + 1;
    end
    if (!rst && val_out && ret_in) got.push_back(data_out);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] e [8]);
    chk({tag, "_count"}, got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk(tag, got[k], e[k]);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    val_in = '0;
    ret_in = 1'b1;
    for (int i = 0; i < 5; i++) dirs[i] = 3'd0;
    step();
    step();
    got.delete();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 8; k++) pat[i][k] = 8'h00;
    rst = 1'b1; val_in = '0; ret_in = 1'b1;
    for (int i = 0; i < 5; i++) dirs[i] = 3'd0;

    do_reset();
    chk("rst_val_out", val_out, 0);
    chk("rst_ret_out", ret_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 0);

    // Single packet from N
    pat[1] = '{8'hAF, 8'hFA, 8'hF8, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    dirs[1] = 3'd2;
    val_in  = 5'b00010;
    chk("single_idle_ret", ret_out, 5'b00000);
    step();
    chk("single_grant_ret", ret_out, 5'b00010);
    chk("single_busy", busy, 1);
    chk("single_no_out_yet", val_out, 0);
    step(); chk("single_f0_val", val_out, 1); chk("single_f0", data_out, 8'hAF);
    step(); chk("single_f1", data_out, 8'hFA);
    step(); chk("single_f2", data_out, 8'hF8);
    step(); chk("single_f3", data_out, 8'hF0); chk("single_busy_drop", busy, 0);
    val_in = '0;
    step(); chk("single_drained", val_out, 0);

    // Contention L vs W, then async reset mid-packet
    do_reset();
    pat[0] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    pat[4] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    dirs[0] = 3'd2; dirs[4] = 3'd2;
    val_in  = 5'b10001;
    step(); chk("cont_first_L", ret_out, 5'b00001);
    for (int k = 0; k < 4; k++) step();
    chk("cont_bubble_ret", ret_out, 5'b00000);
    chk("cont_bubble_busy", busy, 0);
    step(); chk("cont_then_W", ret_out, 5'b10000);
    for (int k = 0; k < 4; k++) step();
    chk("cont_W_done", busy, 0);
    step(); chk("cont_next_L", ret_out, 5'b00001);
    step(); chk("cont_L2_val", val_out, 1); chk("cont_L2_data", data_out, 8'h14);
    chk_seq("cont_order", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h40, 8'h41, 8'h42, 8'h43});
    rst = 1'b1;
    #2;
    chk("async_val_out", val_out, 0);
    chk("async_ret_out", ret_out, 0);
    chk("async_busy", busy, 0);
    chk("async_data_out", data_out, 0);

    // Backpressure: fill FIFO, check stall, then drain
    do_reset();
    ret_in  = 1'b0;
    pat[1]  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    dirs[1] = 3'd2;
    val_in  = 5'b00010;
    for (int k = 0; k < 5; k++) step();
    chk("bp_pkt1_done", busy, 0);
    chk("bp_head", data_out, 8'h21);
    step(); chk("bp_regrant", busy, 1); chk("bp_full_stall", ret_out, 5'b00000);
    step(); step(); chk("bp_still_stalled", ret_out, 5'b00000);
    ret_in = 1'b1;
    chk("bp_full_blocks_same_cycle", ret_out, 5'b00000);
    step(); chk("bp_resume", ret_out, 5'b00010); chk("bp_head2", data_out, 8'h22);
    wait_idle("bp", 20);
    val_in = '0;
    for (int k = 0; k < 8; k++) step();
    chk("bp_empty", val_out, 0);
    chk_seq("bp_order", '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28});

    // Non-matching and out-of-range direction codes
    do_reset();
    dirs[0] = 3'd7; dirs[1] = 3'd3; dirs[2] = 3'd1; dirs[3] = 3'd0; dirs[4] = 3'd5;
    val_in  = 5'h1F;
    for (int k = 0; k < 3; k++) step();
    chk("mis_ret_out", ret_out, 0);
    chk("mis_busy", busy, 0);
    chk("mis_val_out", val_out, 0);

    // Wormhole lock: L stalls mid-packet while S requests
    do_reset();
    pat[0] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    pat[3] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    dirs[0] = 3'd2; dirs[3] = 3'd2;
    val_in  = 5'b00001;
    step(); step(); step();
    val_in  = 5'b01000;
    dirs[0] = 3'd4;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_grant_held", ret_out, 5'b00001);
    end
    val_in = 5'b01001;
    wait_idle("lock_L", 20);
    step(); chk("lock_then_S", ret_out, 5'b01000);
    wait_idle("lock_S", 20);
    val_in = '0;
    for (int k = 0; k < 6; k++) step();
    chk_seq("lock_order", '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h62, 8'h63});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
